// File: rtl/boot_sequencer.sv
// boot_sequencer: loads a header-framed host stream into IMEM/DMEM of core main, then runs it for a bounded time.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum word that must match before the core is released.
module boot_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       run_len,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DATA_W-1:0] host_data,
    input  logic              cpu_halt,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] instructionAddress,
    output logic              instr_we,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] dataAddress,
    output logic              writeEnable,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = ADDR_W + 1;
    typedef enum logic [3:0] {
        IDLE, ICNT, ILOAD, DCNT, DLOAD,
`ifdef BOOT_CHECKSUM_EN
        CSUM,
`endif
        RUN, DONE, ERR
    } state_t;
    state_t state, nxt, run_tgt, after_data;
    logic [CW-1:0] cnt, cnt_nx, n, hdr_n;
    logic [15:0] run_len_q, run_cnt;
    logic accept, hdr_bad, idle_like, last;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif
    assign idle_like  = state inside {IDLE, DONE, ERR};
    assign host_ready = !idle_like && state != RUN;
    assign busy       = !idle_like;
    assign cpu_run    = state == RUN;
    assign done       = state == DONE;
    assign err        = state == ERR;
    assign accept     = host_valid && host_ready;
    assign cnt_nx     = cnt + CW'(1);
    assign last       = cnt_nx == n;
    assign hdr_n      = host_data[CW-1:0];
    assign hdr_bad    = (|host_data[DATA_W-1:8]) || host_data[7:0] > 8'(2**ADDR_W);
    assign run_tgt    = run_len_q == 16'd0 ? DONE : RUN;
`ifdef BOOT_CHECKSUM_EN
    assign after_data = CSUM;
`else
    assign after_data = run_tgt;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? ICNT : state;
            ICNT:  if (accept) nxt = hdr_bad ? ERR : hdr_n == '0 ? DCNT : ILOAD;
            ILOAD: if (accept && last) nxt = DCNT;
            DCNT:  if (accept) nxt = hdr_bad ? ERR : hdr_n == '0 ? after_data : DLOAD;
            DLOAD: if (accept && last) nxt = after_data;
`ifdef BOOT_CHECKSUM_EN
            CSUM:  if (accept) nxt = host_data == acc ? run_tgt : ERR;
`endif
            RUN:   if (cpu_halt || run_cnt == run_len_q - 16'd1) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    // Strobes are registered so each accepted word is written exactly one cycle later.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            instruction        <= '0;
            instructionAddress <= '0;
            instr_we           <= 1'b0;
            data               <= '0;
            dataAddress        <= '0;
            writeEnable        <= 1'b0;
            cnt                <= '0;
            n                  <= '0;
            run_len_q          <= '0;
            run_cnt            <= '0;
`ifdef BOOT_CHECKSUM_EN
            acc                <= '0;
`endif
        end else begin
            instr_we    <= accept && state == ILOAD;
            writeEnable <= accept && state == DLOAD;
            run_cnt     <= state == RUN ? run_cnt + 16'd1 : 16'd0;
            if (start && idle_like) run_len_q <= run_len;
            if (accept && (state == ICNT || state == DCNT)) begin
                n   <= hdr_n;
                cnt <= '0;
            end
            if (accept && state == ILOAD) begin
                instruction        <= host_data;
                instructionAddress <= cnt[ADDR_W-1:0];
                cnt                <= cnt_nx;
            end
            if (accept && state == DLOAD) begin
                data        <= host_data;
                dataAddress <= cnt[ADDR_W-1:0];
                cnt         <= cnt_nx;
            end
`ifdef BOOT_CHECKSUM_EN
            if (start && idle_like) acc <= '0;
            else if (accept && (state == ILOAD || state == DLOAD)) acc <= acc ^ host_data;
`endif
        end
endmodule
